updown_counter_param: RTL

UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

---
 rtl/updown_pkg.sv | 11 +
 rtl/updown_next_calc.sv | 87 ++++++++
 rtl/updown_counter_param.sv | 59 +++++
 3 files changed

// File: rtl/updown_pkg.sv
// Shared mode encodings for the parameterised up/down/bounce counter.
package updown_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

endpackage

// File: rtl/updown_next_calc.sv
// Combinational next-state calculation: next count, next direction and wrap pulse.
module updown_next_calc
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             enable,
  input  mode_t            mode,
  output logic [WIDTH-1:0] next_count,
  output logic             next_dir,
  output logic             next_wrap
);

  logic at_top;
  logic at_zero;
  logic above;

  assign at_top  = (count >= limit);
  assign at_zero = (count == '0);
  assign above   = (count > limit);

  always_comb begin
    next_count = count;
    next_dir   = dir;
    next_wrap  = 1'b0;
    if (load) begin
      next_count = (load_val > limit) ? limit : load_val;
    end else if (enable) begin
      case (mode)
        MODE_UP: begin
          next_dir = 1'b1;
          if (!at_top) begin
            next_count = count + WIDTH'(1);
          end else if (SATURATE) begin
            next_count = limit;
          end else begin
            next_count = '0;
            next_wrap  = 1'b1;
          end
        end
        MODE_DOWN: begin
          next_dir = 1'b0;
          if (at_zero) begin
            if (!SATURATE) begin
              next_count = limit;
              next_wrap  = 1'b1;
            end
          end else if (above) begin
            next_count = limit;
          end else begin
            next_count = count - WIDTH'(1);
          end
        end
        MODE_BOUNCE: begin
          // A zero limit leaves nowhere to bounce; pin at zero without reversing.
          if (limit == '0) begin
            next_count = '0;
          end else if (dir) begin
            if (!at_top) begin
              next_count = count + WIDTH'(1);
            end else begin
              next_count = limit - WIDTH'(1);
              next_dir   = 1'b0;
              next_wrap  = 1'b1;
            end
          end else if (at_zero) begin
            next_count = WIDTH'(1);
            next_dir   = 1'b1;
            next_wrap  = 1'b1;
          end else if (above) begin
            next_count = limit;
          end else begin
            next_count = count - WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parameterised up/down/bounce counter: state registers plus bound flags.
module updown_counter_param
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  logic [WIDTH-1:0] next_count;
  logic             next_dir;
  logic             next_wrap;

  updown_next_calc #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_next (
    .count      (count),
    .dir        (dir),
    .load       (load),
    .load_val   (load_val),
    .limit      (limit),
    .enable     (enable),
    .mode       (mode_t'(mode)),
    .next_count (next_count),
    .next_dir   (next_dir),
    .next_wrap  (next_wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= WIDTH'(RESET_VAL);
      dir   <= 1'b1;
      wrap  <= 1'b0;
    end else begin
      count <= next_count;
      dir   <= next_dir;
      wrap  <= next_wrap;
    end
  end

  // Bound flags follow limit combinationally so a lowered limit shows at once.
  assign at_max = (count >= limit);
  assign at_min = (count == '0);

endmodule
